// File: rtl/wb_ctrl_pkg.sv
// wb_ctrl_pkg: shared widths, the writeback request record and small helpers
// used by the writeback controller, its load-return FIFO and its checker.
package wb_ctrl_pkg;

  localparam int TRD_W   = 3;
  localparam int REG_W   = 5;
  localparam int DATA_W  = 32;
  localparam int NUM_TRD = 8;

  // One register write: used for ALU results, load returns and FIFO entries.
  typedef struct packed {
    logic [TRD_W-1:0]  trd;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  // r0/r1 are not writable; results aimed at them are dropped.
  function automatic logic rd_writable(input logic [REG_W-1:0] rd);
    return (rd > REG_W'(1));
  endfunction

endpackage

// File: rtl/wb_ctrl_chk.sv
// wb_ctrl_chk: protocol and safety assertions for wb_ctrl.
// Ports: clk, rst_n; i_pend_flat (all pending counters); the increment and
//        both decrement sources; the registered write and init outputs.
module wb_ctrl_chk import wb_ctrl_pkg::*; #(
  parameter int PEND_W = 3
) (
  input logic                      clk,
  input logic                      rst_n,
  input logic [NUM_TRD*PEND_W-1:0] i_pend_flat,
  input logic                      i_inc_vld,
  input logic [TRD_W-1:0]          i_inc_trd,
  input logic                      i_pop_vld,
  input logic [TRD_W-1:0]          i_pop_trd,
  input logic                      i_drop_vld,
  input logic [TRD_W-1:0]          i_drop_trd,
  input logic                      i_wr_en,
  input logic [TRD_W-1:0]          i_wr_trd,
  input logic                      i_init,
  input logic [TRD_W-1:0]          i_new_trd
);

  logic [NUM_TRD-1:0] w_ovf;
  logic [NUM_TRD-1:0] w_unf;

  // Per-thread overflow (issue at max count) and underflow (decrement past 0).
  always_comb begin
    w_ovf = {NUM_TRD{1'b0}};
    w_unf = {NUM_TRD{1'b0}};
    for (int t = 0; t < NUM_TRD; t++) begin
      w_ovf[t] = (i_inc_vld && i_inc_trd == TRD_W'(t))
               && !(i_pop_vld && i_pop_trd == TRD_W'(t))
               && !(i_drop_vld && i_drop_trd == TRD_W'(t))
               && (i_pend_flat[t*PEND_W +: PEND_W] == {PEND_W{1'b1}});
      w_unf[t] = (int'(i_pop_vld && i_pop_trd == TRD_W'(t))
                + int'(i_drop_vld && i_drop_trd == TRD_W'(t)))
               > (int'(i_pend_flat[t*PEND_W +: PEND_W])
                + int'(i_inc_vld && i_inc_trd == TRD_W'(t)));
    end
  end

  a_no_pend_ovf: assert property (@(posedge clk) disable iff (!rst_n) (w_ovf == {NUM_TRD{1'b0}}));
  a_no_pend_unf: assert property (@(posedge clk) disable iff (!rst_n) (w_unf == {NUM_TRD{1'b0}}));
  a_no_init_wr_same_trd: assert property (@(posedge clk) disable iff (!rst_n)
    !(i_wr_en && i_init && (i_wr_trd == i_new_trd)));

endmodule

// File: rtl/wb_ld_fifo.sv
// wb_ld_fifo: synchronous FIFO of wb_req_t buffering load returns until the
// regfile write slot is free. No bypass: a pushed entry is visible at the
// head one cycle later. Push and pop in one cycle are both honoured.
// Ports: clk, rst_n (async, active-low); i_push/i_push_data write side;
//        i_pop/o_head read side; o_full/o_empty status flags.
module wb_ld_fifo import wb_ctrl_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    i_push,
  input  wb_req_t i_push_data,
  input  logic    i_pop,
  output wb_req_t o_head,
  output logic    o_full,
  output logic    o_empty
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  wb_req_t     r_mem [DEPTH];
  logic        w_push;
  logic        w_pop;

  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_head  = r_mem[r_rptr[AW-1:0]];

  // Read/write pointer update; reset empties the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= {(AW+1){1'b0}};
      r_rptr <= {(AW+1){1'b0}};
    end else begin
      if (w_push) r_wptr <= r_wptr + (AW+1)'(1);
      else        r_wptr <= r_wptr;
      if (w_pop)  r_rptr <= r_rptr + (AW+1)'(1);
      else        r_rptr <= r_rptr;
    end
  end

  // Entry storage; contents are only observed through valid pointers.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= i_push_data;
  end

endmodule

// File: rtl/wb_ctrl.sv
// wb_ctrl: writeback controller, the single writer of the regfile write and
// init ports. Merges unstallable ALU results with buffered load returns (ALU
// wins), tracks outstanding loads per thread and sequences thread-spawn init
// so it never collides with a write to the same thread.
// Ports: clk, rst_n (async, active-low); i_alu_* ALU results; i_ld_issue*
//        load issue; i_ld_*/o_ld_rdy load returns; i_spawn_*/o_spawn_rdy
//        spawn requests; o_wr_*/o_reg_wr regfile write; o_init/o_new_trd/
//        o_init_data thread init; o_ld_pend per-thread outstanding-load flags.
module wb_ctrl import wb_ctrl_pkg::*; #(
  parameter int LD_FIFO_DEPTH = 4,
  parameter int PEND_W        = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_alu_vld,
  input  logic [TRD_W-1:0]   i_alu_trd,
  input  logic [REG_W-1:0]   i_alu_rd,
  input  logic [DATA_W-1:0]  i_alu_data,
  input  logic               i_ld_issue,
  input  logic [TRD_W-1:0]   i_ld_issue_trd,
  input  logic               i_ld_vld,
  output logic               o_ld_rdy,
  input  logic [TRD_W-1:0]   i_ld_trd,
  input  logic [REG_W-1:0]   i_ld_rd,
  input  logic [DATA_W-1:0]  i_ld_data,
  input  logic               i_spawn_vld,
  output logic               o_spawn_rdy,
  input  logic [TRD_W-1:0]   i_spawn_trd,
  input  logic [DATA_W-1:0]  i_spawn_data,
  output logic               o_wr_en,
  output logic [TRD_W-1:0]   o_wr_trd,
  output logic [REG_W-1:0]   o_reg_wr,
  output logic [DATA_W-1:0]  o_wr_data,
  output logic               o_init,
  output logic [TRD_W-1:0]   o_new_trd,
  output logic [DATA_W-1:0]  o_init_data,
  output logic [NUM_TRD-1:0] o_ld_pend
);

  // Saturating counter step; out-of-range cases are protocol errors that the
  // checker flags, so the counter clamps instead of wrapping.
  function automatic logic [PEND_W-1:0] pend_next(input logic [PEND_W-1:0] cur,
                                                  input logic inc,
                                                  input logic dec_a,
                                                  input logic dec_b);
    logic [PEND_W+1:0] w_up;
    logic [PEND_W+1:0] w_dn;
    logic [PEND_W+1:0] w_diff;
    w_up   = {2'b00, cur} + {{(PEND_W+1){1'b0}}, inc};
    w_dn   = {{(PEND_W+1){1'b0}}, dec_a} + {{(PEND_W+1){1'b0}}, dec_b};
    w_diff = w_up - w_dn;
    if (w_dn > w_up) begin
      return {PEND_W{1'b0}};
    end else if (w_diff > {2'b00, {PEND_W{1'b1}}}) begin
      return {PEND_W{1'b1}};
    end else begin
      return w_diff[PEND_W-1:0];
    end
  endfunction

  logic [PEND_W-1:0]         r_pend [NUM_TRD];
  logic [PEND_W-1:0]         w_pend_nxt [NUM_TRD];
  logic [NUM_TRD*PEND_W-1:0] w_pend_flat;
  logic                      r_wr_en;
  logic [TRD_W-1:0]          r_wr_trd;
  logic [REG_W-1:0]          r_reg_wr;
  logic [DATA_W-1:0]         r_wr_data;
  logic                      r_init;
  logic [TRD_W-1:0]          r_new_trd;
  logic [DATA_W-1:0]         r_init_data;
  logic [NUM_TRD-1:0]        r_ld_pend;

  wb_req_t w_ld_req;
  wb_req_t w_head;
  logic    w_fifo_full;
  logic    w_fifo_empty;
  logic    w_alu_win;
  logic    w_ld_acc;
  logic    w_push;
  logic    w_drop;
  logic    w_pop;
  logic    w_spawn_acc;

  assign w_ld_req     = {i_ld_trd, i_ld_rd, i_ld_data};
  assign w_alu_win    = i_alu_vld & rd_writable(i_alu_rd);
  assign o_ld_rdy     = ~w_fifo_full;
  assign w_ld_acc     = i_ld_vld & o_ld_rdy;
  assign w_push       = w_ld_acc & rd_writable(i_ld_rd);
  assign w_drop       = w_ld_acc & ~rd_writable(i_ld_rd);
  assign w_pop        = ~w_alu_win & ~w_fifo_empty;
  // r_ld_pend always equals (r_pend != 0), so it stands in for the count here.
  assign o_spawn_rdy  = ~r_ld_pend[i_spawn_trd]
                      & ~(i_alu_vld & (i_alu_trd == i_spawn_trd))
                      & ~(i_ld_issue & (i_ld_issue_trd == i_spawn_trd));
  assign w_spawn_acc  = i_spawn_vld & o_spawn_rdy;

  assign o_wr_en     = r_wr_en;
  assign o_wr_trd    = r_wr_trd;
  assign o_reg_wr    = r_reg_wr;
  assign o_wr_data   = r_wr_data;
  assign o_init      = r_init;
  assign o_new_trd   = r_new_trd;
  assign o_init_data = r_init_data;
  assign o_ld_pend   = r_ld_pend;

  wb_ld_fifo #(.DEPTH(LD_FIFO_DEPTH)) u_ld_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_push_data (w_ld_req),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty)
  );

  // Next pending count per thread: +1 on issue, -1 on pop, -1 on dropped accept.
  always_comb begin
    w_pend_flat = {(NUM_TRD*PEND_W){1'b0}};
    for (int t = 0; t < NUM_TRD; t++) begin
      w_pend_nxt[t] = pend_next(r_pend[t],
                                i_ld_issue && (i_ld_issue_trd == TRD_W'(t)),
                                w_pop && (w_head.trd == TRD_W'(t)),
                                w_drop && (i_ld_trd == TRD_W'(t)));
      w_pend_flat[t*PEND_W +: PEND_W] = r_pend[t];
    end
  end

  // Pending counters and their registered nonzero flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int t = 0; t < NUM_TRD; t++) r_pend[t] <= {PEND_W{1'b0}};
      r_ld_pend <= {NUM_TRD{1'b0}};
    end else begin
      for (int t = 0; t < NUM_TRD; t++) begin
        r_pend[t]    <= w_pend_nxt[t];
        r_ld_pend[t] <= (w_pend_nxt[t] != {PEND_W{1'b0}});
      end
    end
  end

  // Write-slot and init output registers; payloads hold while strobes are low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_en     <= 1'b0;
      r_wr_trd    <= {TRD_W{1'b0}};
      r_reg_wr    <= {REG_W{1'b0}};
      r_wr_data   <= {DATA_W{1'b0}};
      r_init      <= 1'b0;
      r_new_trd   <= {TRD_W{1'b0}};
      r_init_data <= {DATA_W{1'b0}};
    end else begin
      if (w_alu_win) begin
        r_wr_en   <= 1'b1;
        r_wr_trd  <= i_alu_trd;
        r_reg_wr  <= i_alu_rd;
        r_wr_data <= i_alu_data;
      end else if (w_pop) begin
        r_wr_en   <= 1'b1;
        r_wr_trd  <= w_head.trd;
        r_reg_wr  <= w_head.rd;
        r_wr_data <= w_head.data;
      end else begin
        r_wr_en   <= 1'b0;
      end
      r_init <= w_spawn_acc;
      if (w_spawn_acc) begin
        r_new_trd   <= i_spawn_trd;
        r_init_data <= i_spawn_data;
      end else begin
        r_new_trd   <= r_new_trd;
        r_init_data <= r_init_data;
      end
    end
  end

  wb_ctrl_chk #(.PEND_W(PEND_W)) u_chk (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_pend_flat (w_pend_flat),
    .i_inc_vld   (i_ld_issue),
    .i_inc_trd   (i_ld_issue_trd),
    .i_pop_vld   (w_pop),
    .i_pop_trd   (w_head.trd),
    .i_drop_vld  (w_drop),
    .i_drop_trd  (i_ld_trd),
    .i_wr_en     (r_wr_en),
    .i_wr_trd    (r_wr_trd),
    .i_init      (r_init),
    .i_new_trd   (r_new_trd)
  );

endmodule

// File: tb/tb_wb_ctrl.sv
// tb_wb_ctrl: directed self-checking bench for wb_ctrl. A table of ALU
// vectors exercises slot priority and payload hold; hand-written sequences
// cover load buffering, FIFO-full backpressure, spawn sequencing and reset.
module tb_wb_ctrl;

  logic        clk;
  logic        rst_n;
  logic        alu_vld;
  logic [2:0]  alu_trd;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_issue;
  logic [2:0]  ld_issue_trd;
  logic        ld_vld;
  logic        ld_rdy;
  logic [2:0]  ld_trd;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        spawn_vld;
  logic        spawn_rdy;
  logic [2:0]  spawn_trd;
  logic [31:0] spawn_data;
  logic        wr_en;
  logic [2:0]  wr_trd;
  logic [4:0]  reg_wr;
  logic [31:0] wr_data;
  logic        init;
  logic [2:0]  new_trd;
  logic [31:0] init_data;
  logic [7:0]  ld_pend;

  int n_chk;
  int n_err;

  wb_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_alu_vld      (alu_vld),
    .i_alu_trd      (alu_trd),
    .i_alu_rd       (alu_rd),
    .i_alu_data     (alu_data),
    .i_ld_issue     (ld_issue),
    .i_ld_issue_trd (ld_issue_trd),
    .i_ld_vld       (ld_vld),
    .o_ld_rdy       (ld_rdy),
    .i_ld_trd       (ld_trd),
    .i_ld_rd        (ld_rd),
    .i_ld_data      (ld_data),
    .i_spawn_vld    (spawn_vld),
    .o_spawn_rdy    (spawn_rdy),
    .i_spawn_trd    (spawn_trd),
    .i_spawn_data   (spawn_data),
    .o_wr_en        (wr_en),
    .o_wr_trd       (wr_trd),
    .o_reg_wr       (reg_wr),
    .o_wr_data      (wr_data),
    .o_init         (init),
    .o_new_trd      (new_trd),
    .o_init_data    (init_data),
    .o_ld_pend      (ld_pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [2:0]  trd;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        e_en;
    logic [2:0]  e_trd;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
  } alu_vec_t;

  alu_vec_t tv [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    alu_vld = 1'b0; alu_trd = 3'd0; alu_rd = 5'd0; alu_data = 32'd0;
    ld_issue = 1'b0; ld_issue_trd = 3'd0;
    ld_vld = 1'b0; ld_trd = 3'd0; ld_rd = 5'd0; ld_data = 32'd0;
    spawn_vld = 1'b0; spawn_trd = 3'd0; spawn_data = 32'd0;
  endtask

  // Advance one cycle; registered outputs are stable 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic alu(input logic [2:0] t, input logic [4:0] r, input logic [31:0] d);
    alu_vld = 1'b1; alu_trd = t; alu_rd = r; alu_data = d;
  endtask

  task automatic ld_ret(input logic [2:0] t, input logic [4:0] r, input logic [31:0] d);
    ld_vld = 1'b1; ld_trd = t; ld_rd = r; ld_data = d;
  endtask

  task automatic issue(input logic [2:0] t);
    ld_issue = 1'b1; ld_issue_trd = t;
    tick();
    ld_issue = 1'b0;
  endtask

  initial begin
    int  drained;
    logic acc5;
    n_chk = 0;
    n_err = 0;
    idle();
    rst_n = 1'b0;

    tv[0] = '{1'b1, 3'd2, 5'd5,  32'hDEAD_BEEF, 1'b1, 3'd2, 5'd5,  32'hDEAD_BEEF};
    tv[1] = '{1'b1, 3'd3, 5'd1,  32'h1111_1111, 1'b0, 3'd2, 5'd5,  32'hDEAD_BEEF};
    tv[2] = '{1'b1, 3'd7, 5'd31, 32'hA5A5_A5A5, 1'b1, 3'd7, 5'd31, 32'hA5A5_A5A5};
    tv[3] = '{1'b1, 3'd4, 5'd0,  32'h2222_2222, 1'b0, 3'd7, 5'd31, 32'hA5A5_A5A5};
    tv[4] = '{1'b0, 3'd5, 5'd9,  32'h3333_3333, 1'b0, 3'd7, 5'd31, 32'hA5A5_A5A5};
    tv[5] = '{1'b1, 3'd0, 5'd2,  32'h0000_0001, 1'b1, 3'd0, 5'd2,  32'h0000_0001};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_data", wr_data, 32'd0);
    chk("rst_init", 32'(init), 32'd0);
    chk("rst_ld_rdy", 32'(ld_rdy), 32'd1);
    chk("rst_ld_pend", 32'(ld_pend), 32'd0);
    rst_n = 1'b1;
    tick();

    // ALU table: priority, rd<=1 drop, payload hold while wr_en=0
    for (int i = 0; i < 6; i++) begin
      alu_vld = tv[i].vld; alu_trd = tv[i].trd; alu_rd = tv[i].rd; alu_data = tv[i].data;
      tick();
      chk($sformatf("alu%0d_wr_en", i), 32'(wr_en), 32'(tv[i].e_en));
      chk($sformatf("alu%0d_wr_trd", i), 32'(wr_trd), 32'(tv[i].e_trd));
      chk($sformatf("alu%0d_reg_wr", i), 32'(reg_wr), 32'(tv[i].e_rd));
      chk($sformatf("alu%0d_wr_data", i), wr_data, tv[i].e_data);
    end
    idle();
    tick();

    // Load t3 r7 waits behind 3 busy ALU cycles
    issue(3'd3);
    chk("a_pend_set", 32'(ld_pend), 32'h08);
    alu(3'd0, 5'd2, 32'h100);
    ld_ret(3'd3, 5'd7, 32'h1234);
    #2;
    chk("a_ld_rdy", 32'(ld_rdy), 32'd1);
    tick();
    ld_vld = 1'b0;
    chk("a_busy0", wr_data, 32'h100);
    chk("a_pend_hold", 32'(ld_pend), 32'h08);
    alu(3'd0, 5'd2, 32'h101);
    tick();
    chk("a_busy1", wr_data, 32'h101);
    alu(3'd0, 5'd2, 32'h102);
    tick();
    chk("a_busy2", wr_data, 32'h102);
    idle();
    tick();
    chk("a_ld_wr_en", 32'(wr_en), 32'd1);
    chk("a_ld_wr_trd", 32'(wr_trd), 32'd3);
    chk("a_ld_reg_wr", 32'(reg_wr), 32'd7);
    chk("a_ld_wr_data", wr_data, 32'h1234);
    chk("a_pend_clr", 32'(ld_pend), 32'h00);
    tick();
    chk("a_after_wr_en", 32'(wr_en), 32'd0);

    // Five returns against a busy ALU: FIFO fills after four
    for (int k = 1; k <= 5; k++) issue(3'(k));
    chk("b_pend", 32'(ld_pend), 32'h3E);
    for (int k = 1; k <= 5; k++) begin
      alu(3'd0, 5'd2, 32'h200 + 32'(k));
      ld_ret(3'(k), 5'(8 + k), 32'(k));
      #2;
      chk($sformatf("b_ld_rdy%0d", k), 32'(ld_rdy), (k <= 4) ? 32'd1 : 32'd0);
      tick();
    end
    alu_vld = 1'b0;
    acc5 = 1'b0;
    drained = 0;
    for (int c = 0; c < 12; c++) begin
      #2;
      if (ld_vld && ld_rdy) acc5 = 1'b1;
      tick();
      if (acc5) ld_vld = 1'b0;
      if (wr_en) begin
        drained++;
        chk("b_drain_data", wr_data, 32'(drained));
        chk("b_drain_trd", 32'(wr_trd), 32'(drained));
        chk("b_drain_rd", 32'(reg_wr), 32'(8 + drained));
      end
    end
    chk("b_drain_count", 32'(drained), 32'd5);
    chk("b_fifth_accepted", 32'(acc5), 32'd1);
    chk("b_pend_clr", 32'(ld_pend), 32'h00);
    idle();

    // Spawn t4 waits for its pending load to pop
    issue(3'd4);
    spawn_vld = 1'b1; spawn_trd = 3'd4; spawn_data = 32'hCAFE;
    #2;
    chk("c_rdy_pend", 32'(spawn_rdy), 32'd0);
    tick();
    ld_ret(3'd4, 5'd9, 32'h55);
    #2;
    chk("c_rdy_accept", 32'(spawn_rdy), 32'd0);
    tick();
    ld_vld = 1'b0;
    #2;
    chk("c_rdy_pop", 32'(spawn_rdy), 32'd0);
    tick();
    chk("c_pop_wr", wr_data, 32'h55);
    chk("c_no_init_yet", 32'(init), 32'd0);
    #2;
    chk("c_rdy_free", 32'(spawn_rdy), 32'd1);
    tick();
    spawn_vld = 1'b0;
    chk("c_init", 32'(init), 32'd1);
    chk("c_new_trd", 32'(new_trd), 32'd4);
    chk("c_init_data", init_data, 32'hCAFE);
    tick();
    chk("c_init_pulse", 32'(init), 32'd0);
    chk("c_new_trd_hold", 32'(new_trd), 32'd4);

    // Spawn t1 alongside an ALU write to t6, then stalls on t1 traffic
    spawn_vld = 1'b1; spawn_trd = 3'd1; spawn_data = 32'hBEE1;
    alu(3'd6, 5'd3, 32'h66);
    #2;
    chk("d_rdy_other", 32'(spawn_rdy), 32'd1);
    tick();
    chk("d_init", 32'(init), 32'd1);
    chk("d_new_trd", 32'(new_trd), 32'd1);
    chk("d_wr_en", 32'(wr_en), 32'd1);
    chk("d_wr_trd", 32'(wr_trd), 32'd6);
    spawn_data = 32'hBEE2;
    alu(3'd1, 5'd3, 32'h77);
    #2;
    chk("d_rdy_alu_same", 32'(spawn_rdy), 32'd0);
    tick();
    chk("d_no_init", 32'(init), 32'd0);
    chk("d_wr_trd1", 32'(wr_trd), 32'd1);
    alu_vld = 1'b0;
    ld_issue = 1'b1; ld_issue_trd = 3'd1;
    #2;
    chk("d_rdy_issue_same", 32'(spawn_rdy), 32'd0);
    tick();
    ld_issue = 1'b0;
    chk("d_pend_t1", 32'(ld_pend), 32'h02);
    ld_ret(3'd1, 5'd0, 32'h99);
    #2;
    chk("d_rdy_pend_t1", 32'(spawn_rdy), 32'd0);
    tick();
    ld_vld = 1'b0;
    chk("d_drop_no_wr", 32'(wr_en), 32'd0);
    chk("d_drop_pend", 32'(ld_pend), 32'h00);
    #2;
    chk("d_rdy_after", 32'(spawn_rdy), 32'd1);
    tick();
    spawn_vld = 1'b0;
    chk("d_init2", 32'(init), 32'd1);
    chk("d_init_data2", init_data, 32'hBEE2);
    tick();

    // Reset with three buffered loads and nonzero pending
    for (int k = 0; k < 3; k++) issue(3'd2);
    for (int k = 0; k < 3; k++) begin
      alu(3'd5, 5'd4, 32'h300 + 32'(k));
      ld_ret(3'd2, 5'(10 + k), 32'h400 + 32'(k));
      tick();
    end
    idle();
    chk("e_pend_pre", 32'(ld_pend), 32'h04);
    rst_n = 1'b0;
    #2;
    chk("e_wr_en", 32'(wr_en), 32'd0);
    chk("e_wr_trd", 32'(wr_trd), 32'd0);
    chk("e_reg_wr", 32'(reg_wr), 32'd0);
    chk("e_wr_data", wr_data, 32'd0);
    chk("e_new_trd", 32'(new_trd), 32'd0);
    chk("e_init_data", init_data, 32'd0);
    chk("e_ld_pend", 32'(ld_pend), 32'd0);
    chk("e_ld_rdy", 32'(ld_rdy), 32'd1);
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("e_no_stale%0d", c), 32'(wr_en), 32'd0);
    end
    chk("e_pend_post", 32'(ld_pend), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
